// File: rtl/fetch_buffer.sv
// Decode-side circular FIFO for fetched packets; flushed on mispredict recovery.
// Optional zero-latency empty bypass enabled by defining FETCH_BUFFER_BYPASS_EN.
module fetch_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [XLEN-1:0]            in_instr,
    input  logic [XLEN-1:0]            in_pc,
    input  logic                       in_pred_taken,
    input  logic [XLEN-1:0]            in_pred_target,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_instr,
    output logic [XLEN-1:0]            out_pc,
    output logic                       out_pred_taken,
    output logic [XLEN-1:0]            out_pred_target,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [XLEN-1:0] instrMem_q  [DEPTH];
    logic [XLEN-1:0] pcMem_q     [DEPTH];
    logic            takenMem_q  [DEPTH];
    logic [XLEN-1:0] targetMem_q [DEPTH];

    logic [PW-1:0] headPtr_q, headPtr_d;
    logic [PW-1:0] tailPtr_q, tailPtr_d;
    logic [CW-1:0] count_q, count_d;

    logic empty;
    logic enq;
    logic deq;
    logic bypassTake;

    assign empty    = (count_q == '0);
    assign in_ready = (count_q != FULL);

`ifdef FETCH_BUFFER_BYPASS_EN
    // An empty buffer hands the incoming packet straight to a ready decoder.
    assign bypassTake = empty & in_valid & out_ready & ~flush;
`else
    assign bypassTake = 1'b0;
`endif

    assign enq = in_valid & in_ready & ~flush & ~bypassTake;
    assign deq = ~empty & out_ready & ~flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                instrMem_q[i]  <= '0;
                pcMem_q[i]     <= '0;
                takenMem_q[i]  <= 1'b0;
                targetMem_q[i] <= '0;
            end
        end else if (enq) begin
            instrMem_q[tailPtr_q]  <= in_instr;
            pcMem_q[tailPtr_q]     <= in_pc;
            takenMem_q[tailPtr_q]  <= in_pred_taken;
            targetMem_q[tailPtr_q] <= in_pred_target;
        end
    end

    always_comb begin
        headPtr_d = headPtr_q;
        tailPtr_d = tailPtr_q;
        count_d   = count_q;
        if (flush) begin
            headPtr_d = '0;
            tailPtr_d = '0;
            count_d   = '0;
        end else begin
            if (enq) tailPtr_d = tailPtr_q + PW'(1);
            if (deq) headPtr_d = headPtr_q + PW'(1);
            case ({enq, deq})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            headPtr_q <= '0;
            tailPtr_q <= '0;
            count_q   <= '0;
        end else begin
            headPtr_q <= headPtr_d;
            tailPtr_q <= tailPtr_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        out_valid       = ~empty;
        out_instr       = instrMem_q[headPtr_q];
        out_pc          = pcMem_q[headPtr_q];
        out_pred_taken  = takenMem_q[headPtr_q];
        out_pred_target = targetMem_q[headPtr_q];
`ifdef FETCH_BUFFER_BYPASS_EN
        // While empty, decode sees the incoming packet whether or not it takes it.
        if (empty && in_valid && !flush) begin
            out_valid       = 1'b1;
            out_instr       = in_instr;
            out_pc          = in_pc;
            out_pred_taken  = in_pred_taken;
            out_pred_target = in_pred_target;
        end
`endif
    end

    assign occupancy = count_q;

endmodule
